// File: rtl/gf_mult_seq_pkg.sv
// Shared types and constants for the digit-serial GF(2^WIDTH) multiplier.
package gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_mult_state_t;

    function automatic bit digit_divides(input int unsigned width, input int unsigned digit);
        return (digit != 0) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/gf_mult_seq_if.sv
// Operand/result handshake bundle for gf_mult_seq; in_poly exists only with GF_MULT_POLY_PORT_EN.
interface gf_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
`ifdef GF_MULT_POLY_PORT_EN
    logic [WIDTH-1:0] in_poly;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;

`ifdef GF_MULT_POLY_PORT_EN
    modport master (
        output in_valid, in_a, in_b, in_poly, out_ready,
        input  in_ready, out_valid, out_p
    );
    modport slave (
        input  in_valid, in_a, in_b, in_poly, out_ready,
        output in_ready, out_valid, out_p
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
`endif
endinterface

// File: rtl/gf_mult_seq_xtime.sv
// Multiply-by-x in GF(2^WIDTH): shift left, fold the dropped top bit back through the polynomial.
module gf_xtime #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] poly_i,
    output logic [WIDTH-1:0] v_o
);

    // Single xtime step
    always_comb begin
        v_o = {v_i[WIDTH-2:0], 1'b0} ^ (v_i[WIDTH-1] ? poly_i : {WIDTH{1'b0}});
    end

endmodule

// File: rtl/gf_mult_seq.sv
// Digit-serial MSB-first Horner GF(2^WIDTH) multiplier with valid/ready on both sides.
// Define GF_MULT_POLY_PORT_EN to take the reduction polynomial from the bus per operation.
module gf_mult_seq
    import gf_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY),
    parameter int unsigned      DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    gf_mult_seq_if.slave bus
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    if (!digit_divides(WIDTH, DIGIT)) begin : g_bad_digit
        $error("gf_mult_seq: DIGIT must divide WIDTH");
    end

    gf_mult_state_t   state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_p_q, out_p_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] poly_s;
    logic [WIDTH-1:0] horner_s;

`ifdef GF_MULT_POLY_PORT_EN
    logic [WIDTH-1:0] poly_q, poly_d;
    assign poly_s = poly_q;
`else
    assign poly_s = POLY;
`endif

    // Horner chain: stage g consumes multiplier bit WIDTH-1-g of the current digit
    for (genvar g = 0; g < DIGIT; g++) begin : g_step
        logic [WIDTH-1:0] acc_in_s;
        logic [WIDTH-1:0] xt_s;
        logic [WIDTH-1:0] acc_s;
        if (g == 0) begin : g_first
            assign acc_in_s = acc_q;
        end else begin : g_next
            assign acc_in_s = g_step[g-1].acc_s;
        end
        gf_xtime #(.WIDTH(WIDTH)) u_xtime (
            .v_i    (acc_in_s),
            .poly_i (poly_s),
            .v_o    (xt_s)
        );
        assign acc_s = xt_s ^ (a_sh_q[WIDTH-1-g] ? b_q : {WIDTH{1'b0}});
    end

    assign horner_s = g_step[DIGIT-1].acc_s;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_sh_d  = a_sh_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        out_p_d = out_p_q;
`ifdef GF_MULT_POLY_PORT_EN
        poly_d  = poly_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d  = bus.in_a;
                    b_d     = bus.in_b;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = CNT_W'(STEPS);
`ifdef GF_MULT_POLY_PORT_EN
                    poly_d  = bus.in_poly;
`endif
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d  = horner_s;
                a_sh_d = a_sh_q << DIGIT;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_p_d = horner_s;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {WIDTH{1'b0}};
            a_sh_q      <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_p_q     <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef GF_MULT_POLY_PORT_EN
            poly_q      <= POLY;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_sh_q      <= a_sh_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            out_p_q     <= out_p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef GF_MULT_POLY_PORT_EN
            poly_q      <= poly_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Bench for gf_mult_seq: default 8-bit AES field plus a 4-bit, 2-digit instance.
module tb_gf_mult_seq;
    import gf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    gf_mult_seq_if #(.WIDTH(8)) bus8 ();
    gf_mult_seq_if #(.WIDTH(4)) bus4 ();

    gf_mult_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    gf_mult_seq #(.WIDTH(4), .POLY(4'h3), .DIGIT(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Polynomial product then long-division reduction by x^w + poly
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] poly, input int w);
        logic [15:0] prod;
        logic [15:0] full;
        logic [15:0] mask;
        prod = 16'd0;
        for (int i = 0; i < w; i++)
            if (a[i]) prod ^= (16'(b) << i);
        full = (16'd1 << w) | 16'(poly);
        for (int i = 2 * w - 2; i >= w; i--)
            if (prod[i]) prod ^= (full << (i - w));
        mask = (16'd1 << w) - 16'd1;
        return 8'(prod & mask);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model of the 8-bit instance: one operation in flight, result due 8 edges after accept
    logic [7:0] exp_q[$];
    bit         inflight = 1'b0;
    bit         armed = 1'b0;
    int         acc_edge = 0;
    initial forever begin
        logic [7:0] poly_now;
        @(negedge clk);
        if (armed) begin
            chk("in_ready", 32'(bus8.in_ready), 32'(!inflight));
            chk("out_valid", 32'(bus8.out_valid), 32'(inflight && ((cyc - acc_edge) >= 8)));
            if (bus8.out_valid && exp_q.size() > 0)
                chk("out_p", 32'(bus8.out_p), 32'(exp_q[0]));
        end
        if (!rst_n) begin
            exp_q.delete();
            inflight = 1'b0;
            armed = 1'b1;
        end else begin
            if (bus8.out_valid && bus8.out_ready && inflight) begin
                void'(exp_q.pop_front());
                inflight = 1'b0;
            end
            if (bus8.in_valid && bus8.in_ready) begin
`ifdef GF_MULT_POLY_PORT_EN
                poly_now = bus8.in_poly;
`else
                poly_now = 8'h1B;
`endif
                exp_q.push_back(gf_ref(bus8.in_a, bus8.in_b, poly_now, 8));
                inflight = 1'b1;
                acc_edge = cyc + 1;
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] poly);
        int t;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b1;
        bus8.in_a = a;
        bus8.in_b = b;
`ifdef GF_MULT_POLY_PORT_EN
        bus8.in_poly = poly;
`else
        if (poly != 8'h1B) $display("note: poly 0x%0h ignored without poly port", poly);
`endif
        t = 0;
        @(negedge clk);
        while (!bus8.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait8(output logic [7:0] p, output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus8.out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus8.out_valid) chk("result_timeout", 32'd0, 32'd1);
        p = bus8.out_p;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
    } vec_t;

    initial begin
        logic [7:0] p;
        int         lat;
        int         t;
        vec_t       vecs[5];
        vecs[0] = '{8'h57, 8'h83, 8'hC1};
        vecs[1] = '{8'h57, 8'h13, 8'hFE};
        vecs[2] = '{8'h02, 8'h87, 8'h15};
        vecs[3] = '{8'hFF, 8'h01, 8'hFF};
        vecs[4] = '{8'h00, 8'hA5, 8'h00};

        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_a = 8'h00; bus8.in_b = 8'h00; bus8.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_a = 4'h0;  bus4.in_b = 4'h0;  bus4.out_ready = 1'b1;
`ifdef GF_MULT_POLY_PORT_EN
        bus8.in_poly = 8'h1B;
        bus4.in_poly = 4'h3;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_out_p", 32'(bus8.out_p), 32'd0);
        chk("rst4_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rst4_out_valid", 32'(bus4.out_valid), 32'd0);

        // Directed products with out_ready tied high
        foreach (vecs[i]) begin
            send8(vecs[i].a, vecs[i].b, 8'h1B);
            wait8(p, lat);
            chk($sformatf("prod_%0h_%0h", vecs[i].a, vecs[i].b), 32'(p), 32'(vecs[i].p));
            chk($sformatf("lat_%0h_%0h", vecs[i].a, vecs[i].b), 32'(lat), 32'd8);
        end

        // Backpressure: result must hold while in_valid pulses are ignored
        @(posedge clk);
        #1 bus8.out_ready = 1'b0;
        send8(8'h57, 8'h83, 8'h1B);
        wait8(p, lat);
        chk("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus8.in_valid = i[0];
            bus8.in_a = 8'($urandom);
            bus8.in_b = 8'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
            chk("bp_out_p", 32'(bus8.out_p), 32'hC1);
            chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(bus8.out_valid), 32'd0);

        // Reset on the 4th BUSY cycle aborts the operation
        send8(8'h57, 8'h83, 8'h1B);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("abort_out_p", 32'(bus8.out_p), 32'd0);
        t = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus8.out_valid) t++;
        end
        chk("abort_no_result", 32'(t), 32'd0);

        // 4-bit field x^4+x+1, two bits per cycle
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b1;
        bus4.in_a = 4'h7;
        bus4.in_b = 4'h9;
        @(negedge clk);
        chk("w4_in_ready", 32'(bus4.in_ready), 32'd1);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus4.out_valid && lat < 50) begin
            chk("w4_busy_in_ready", 32'(bus4.in_ready), 32'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w4_lat", 32'(lat), 32'd2);
        chk("w4_prod", 32'(bus4.out_p), 32'hA);
        chk("w4_model", 32'(bus4.out_p), 32'(gf_ref(8'h7, 8'h9, 8'h3, 4)));

`ifdef GF_MULT_POLY_PORT_EN
        // Runtime-selected field
        send8(8'h57, 8'h83, 8'h1B);
        wait8(p, lat);
        chk("poly1b_prod", 32'(p), 32'hC1);
        send8(8'h57, 8'h83, 8'h1D);
        wait8(p, lat);
        chk("poly1d_prod", 32'(p), 32'(gf_ref(8'h57, 8'h83, 8'h1D, 8)));
        chk("poly1d_lat", 32'(lat), 32'd8);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
